calf_node_iface: RTL and testbench

//  Node-side network interface feeding brouter's local port (port4).

---
 rtl/calf_node_iface.sv | 133 +++++++++++++
 tb/tb_calf_node_iface.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calf_node_iface.sv
// Node-side network interface for a brouter local port: an injection FIFO toward port4,
// an ejection FIFO from port4 with a sticky overflow flag, and a head-of-line starvation monitor.
module calf_node_iface #(
    parameter int CTRL_W    = 64,
    parameter int VALID_BIT = 63,
    parameter int IQ_DEPTH  = 4,
    parameter int EQ_DEPTH  = 4,
    parameter int STARVE_W  = 8,
    parameter int STARVE_TH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CTRL_W-1:0]          core_in_flit,
    input  logic                       core_in_valid,
    output logic                       core_in_ready,
    output logic [CTRL_W-1:0]          port4_ci,
    input  logic                       port4_ack,
    input  logic [CTRL_W-1:0]          port4_co,
    output logic [CTRL_W-1:0]          core_out_flit,
    output logic                       core_out_valid,
    input  logic                       core_out_ready,
    output logic [$clog2(IQ_DEPTH):0]  inj_count,
    output logic                       inj_starve,
    output logic                       ej_overflow
);
    localparam int IQ_PW = $clog2(IQ_DEPTH);
    localparam int IQ_CW = IQ_PW + 1;
    localparam int EQ_PW = $clog2(EQ_DEPTH);
    localparam int EQ_CW = EQ_PW + 1;

    logic [CTRL_W-1:0]   iq_mem_q [IQ_DEPTH];
    logic [CTRL_W-1:0]   iq_mem_d [IQ_DEPTH];
    logic [IQ_PW-1:0]    iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
    logic [IQ_CW-1:0]    iq_cnt_q, iq_cnt_d;
    logic                iq_full, iq_empty, iq_push, iq_pop;

    logic [CTRL_W-1:0]   eq_mem_q [EQ_DEPTH];
    logic [CTRL_W-1:0]   eq_mem_d [EQ_DEPTH];
    logic [EQ_PW-1:0]    eq_wr_q, eq_wr_d, eq_rd_q, eq_rd_d;
    logic [EQ_CW-1:0]    eq_cnt_q, eq_cnt_d;
    logic                eq_full, eq_empty, eq_req, eq_push, eq_pop;
    logic                ovf_q, ovf_d;

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                starve_q, starve_d;

    // Injection side: ready comes from the registered count only, so a full queue
    // cannot take a new flit in the same cycle its head is acked.
    always_comb begin
        iq_full       = (iq_cnt_q == IQ_CW'(IQ_DEPTH));
        iq_empty      = (iq_cnt_q == '0);
        core_in_ready = rst_n & ~iq_full;
        iq_push       = core_in_valid & ~iq_full;
        iq_pop        = ~iq_empty & port4_ack;
        port4_ci      = iq_empty ? '0 : iq_mem_q[iq_rd_q];
        inj_count     = iq_cnt_q;

        iq_mem_d = iq_mem_q;
        if (iq_push) iq_mem_d[iq_wr_q] = core_in_flit;
        iq_wr_d = iq_push ? iq_wr_q + IQ_PW'(1) : iq_wr_q;
        iq_rd_d = iq_pop  ? iq_rd_q + IQ_PW'(1) : iq_rd_q;
        case ({iq_push, iq_pop})
            2'b10:   iq_cnt_d = iq_cnt_q + IQ_CW'(1);
            2'b01:   iq_cnt_d = iq_cnt_q - IQ_CW'(1);
            default: iq_cnt_d = iq_cnt_q;
        endcase
    end

    always_comb begin
        if (iq_empty || iq_pop)
            starve_cnt_d = '0;
        else if (starve_cnt_q != '1)
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        else
            starve_cnt_d = starve_cnt_q;
        starve_d   = (starve_cnt_d >= STARVE_W'(STARVE_TH));
        inj_starve = starve_q;
    end

    // Ejection side: the router cannot be stalled, so a flit arriving at a full queue
    // is accepted only if the core frees a slot in the same cycle; otherwise it is lost.
    always_comb begin
        eq_full        = (eq_cnt_q == EQ_CW'(EQ_DEPTH));
        eq_empty       = (eq_cnt_q == '0);
        eq_req         = port4_co[VALID_BIT];
        eq_pop         = ~eq_empty & core_out_ready;
        eq_push        = eq_req & (~eq_full | eq_pop);
        ovf_d          = ovf_q | (eq_req & eq_full & ~eq_pop);
        core_out_valid = ~eq_empty;
        core_out_flit  = eq_empty ? '0 : eq_mem_q[eq_rd_q];
        ej_overflow    = ovf_q;

        eq_mem_d = eq_mem_q;
        if (eq_push) eq_mem_d[eq_wr_q] = port4_co;
        eq_wr_d = eq_push ? eq_wr_q + EQ_PW'(1) : eq_wr_q;
        eq_rd_d = eq_pop  ? eq_rd_q + EQ_PW'(1) : eq_rd_q;
        case ({eq_push, eq_pop})
            2'b10:   eq_cnt_d = eq_cnt_q + EQ_CW'(1);
            2'b01:   eq_cnt_d = eq_cnt_q - EQ_CW'(1);
            default: eq_cnt_d = eq_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iq_wr_q      <= '0;
            iq_rd_q      <= '0;
            iq_cnt_q     <= '0;
            eq_wr_q      <= '0;
            eq_rd_q      <= '0;
            eq_cnt_q     <= '0;
            ovf_q        <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            iq_wr_q      <= iq_wr_d;
            iq_rd_q      <= iq_rd_d;
            iq_cnt_q     <= iq_cnt_d;
            eq_wr_q      <= eq_wr_d;
            eq_rd_q      <= eq_rd_d;
            eq_cnt_q     <= eq_cnt_d;
            ovf_q        <= ovf_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    // Storage needs no reset: outputs are masked to zero whenever a queue is empty.
    always_ff @(posedge clk) begin
        iq_mem_q <= iq_mem_d;
        eq_mem_q <= eq_mem_d;
    end
endmodule

// File: tb/tb_calf_node_iface.sv
// Bench for calf_node_iface: vector table, directed corner sequences, and a
// randomized run compared against a queue-based reference model.
module tb_calf_node_iface;
    localparam int IQ_D = 4;
    localparam int EQ_D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] core_in_flit;
    logic        core_in_valid;
    logic        core_in_ready;
    logic [63:0] port4_ci;
    logic        port4_ack;
    logic [63:0] port4_co;
    logic [63:0] core_out_flit;
    logic        core_out_valid;
    logic        core_out_ready;
    logic [2:0]  inj_count;
    logic        inj_starve;
    logic        ej_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    calf_node_iface dut (
        .clk(clk), .rst_n(rst_n),
        .core_in_flit(core_in_flit), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .port4_ci(port4_ci), .port4_ack(port4_ack), .port4_co(port4_co),
        .core_out_flit(core_out_flit), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .inj_count(inj_count), .inj_starve(inj_starve), .ej_overflow(ej_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] ifl;
        logic        ack;
        logic [63:0] co;
        logic        ordy;
        int          cnt;
        logic [63:0] ci;
        logic        rdy;
        logic        ov;
        logic [63:0] of;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [63:0] ifl, logic ack, logic [63:0] co, logic ordy,
                                int cnt, logic [63:0] ci, logic rdy, logic ov, logic [63:0] of, logic ovf);
        vec_t v;
        v.iv = iv; v.ifl = ifl; v.ack = ack; v.co = co; v.ordy = ordy;
        v.cnt = cnt; v.ci = ci; v.rdy = rdy; v.ov = ov; v.of = of; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_in_valid = 1'b0; core_in_flit = '0; port4_ack = 1'b0;
        port4_co = '0; core_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model: plain queues driven by the interface rules.
    logic [63:0] mq_i[$];
    logic [63:0] mq_e[$];
    int          m_wait;
    bit          m_starve;
    bit          m_ovf;

    task automatic model_reset();
        mq_i.delete(); mq_e.delete();
        m_wait = 0; m_starve = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit ipop, ipush, epop;
        ipop  = (mq_i.size() > 0) && port4_ack;
        ipush = core_in_valid && (mq_i.size() < IQ_D);
        if (mq_i.size() == 0 || ipop) m_wait = 0;
        else if (m_wait < 255) m_wait++;
        m_starve = (m_wait >= 32);
        if (ipop) void'(mq_i.pop_front());
        if (ipush) mq_i.push_back(core_in_flit);
        epop = (mq_e.size() > 0) && core_out_ready;
        if (epop) void'(mq_e.pop_front());
        if (port4_co[63]) begin
            if (mq_e.size() < EQ_D) mq_e.push_back(port4_co);
            else m_ovf = 1;
        end
    endtask

    task automatic model_compare(input int k);
        chk($sformatf("rnd%0d_cnt", k), 64'(inj_count), 64'(mq_i.size()));
        chk($sformatf("rnd%0d_ci", k), port4_ci, mq_i.size() > 0 ? mq_i[0] : 64'd0);
        chk($sformatf("rnd%0d_rdy", k), 64'(core_in_ready), 64'(mq_i.size() < IQ_D));
        chk($sformatf("rnd%0d_starve", k), 64'(inj_starve), 64'(m_starve));
        chk($sformatf("rnd%0d_ov", k), 64'(core_out_valid), 64'(mq_e.size() > 0));
        chk($sformatf("rnd%0d_of", k), core_out_flit, mq_e.size() > 0 ? mq_e[0] : 64'd0);
        chk($sformatf("rnd%0d_ovf", k), 64'(ej_overflow), 64'(m_ovf));
    endtask

    localparam logic [63:0] A  = 64'h8000_0000_0000_00A0;
    localparam logic [63:0] B  = 64'h8000_0000_0000_00B0;
    localparam logic [63:0] F1 = 64'h8000_0000_0000_0F01;
    localparam logic [63:0] F2 = 64'h8000_0000_0000_0F02;
    localparam logic [63:0] F3 = 64'h8000_0000_0000_0F03;
    localparam logic [63:0] F4 = 64'h8000_0000_0000_0F04;
    localparam logic [63:0] F5 = 64'h8000_0000_0000_0F05;
    localparam logic [63:0] E1 = 64'h8000_0000_0000_0E01;
    localparam logic [63:0] E2 = 64'h8000_0000_0000_0E02;
    localparam logic [63:0] E3 = 64'h8000_0000_0000_0E03;
    localparam logic [63:0] E4 = 64'h8000_0000_0000_0E04;
    localparam logic [63:0] E5 = 64'h8000_0000_0000_0E05;
    localparam logic [63:0] NV = 64'h0000_0000_DEAD_BEEF;

    initial begin
        // iv ifl ack co ordy | cnt ci rdy ov of ovf
        tbl.push_back(mk(1, A,  0, 0, 0,  1, A,  1, 0, 0, 0));
        tbl.push_back(mk(1, B,  0, 0, 0,  2, A,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 0,  1, B,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 0,  0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 0,  0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, F1, 0, 0, 0,  1, F1, 1, 0, 0, 0));
        tbl.push_back(mk(1, F2, 0, 0, 0,  2, F1, 1, 0, 0, 0));
        tbl.push_back(mk(1, F3, 0, 0, 0,  3, F1, 1, 0, 0, 0));
        tbl.push_back(mk(1, F4, 0, 0, 0,  4, F1, 0, 0, 0, 0));
        tbl.push_back(mk(1, F5, 1, 0, 0,  3, F2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 0,  2, F3, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 0,  1, F4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  1, 0, 0,  0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0, NV, 0, 0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0, E1, 0, 0, 0,  1, 1, E1, 0));
        tbl.push_back(mk(0, 0,  0, E2, 0, 0, 0,  1, 1, E1, 0));
        tbl.push_back(mk(0, 0,  0, E3, 0, 0, 0,  1, 1, E1, 0));
        tbl.push_back(mk(0, 0,  0, E4, 0, 0, 0,  1, 1, E1, 0));
        tbl.push_back(mk(0, 0,  0, E5, 0, 0, 0,  1, 1, E1, 1));
        tbl.push_back(mk(0, 0,  0, 0,  1, 0, 0,  1, 1, E2, 1));
        tbl.push_back(mk(0, 0,  0, 0,  1, 0, 0,  1, 1, E3, 1));
        tbl.push_back(mk(0, 0,  0, 0,  1, 0, 0,  1, 1, E4, 1));
        tbl.push_back(mk(0, 0,  0, 0,  1, 0, 0,  1, 0, 0,  1));

        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk("rst_rdy", 64'(core_in_ready), 64'd0);
        chk("rst_cnt", 64'(inj_count), 64'd0);
        chk("rst_ci", port4_ci, 64'd0);
        chk("rst_ov", 64'(core_out_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_rdy", 64'(core_in_ready), 64'd1);

        foreach (tbl[i]) begin
            core_in_valid = tbl[i].iv; core_in_flit = tbl[i].ifl; port4_ack = tbl[i].ack;
            port4_co = tbl[i].co; core_out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("vec%0d_cnt", i), 64'(inj_count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_ci", i), port4_ci, tbl[i].ci);
            chk($sformatf("vec%0d_rdy", i), 64'(core_in_ready), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d_ov", i), 64'(core_out_valid), 64'(tbl[i].ov));
            chk($sformatf("vec%0d_of", i), core_out_flit, tbl[i].of);
            chk($sformatf("vec%0d_ovf", i), 64'(ej_overflow), 64'(tbl[i].ovf));
        end
        idle_inputs();

        // Reset in the middle of traffic, with the sticky overflow still set.
        for (int i = 0; i < 3; i++) begin
            core_in_valid = 1'b1; core_in_flit = F1 + 64'(i); port4_co = E1 + 64'(i);
            tick();
        end
        idle_inputs();
        chk("mid_cnt_pre", 64'(inj_count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'(inj_count), 64'd0);
        chk("mid_rst_ci", port4_ci, 64'd0);
        chk("mid_rst_rdy", 64'(core_in_ready), 64'd0);
        chk("mid_rst_ov", 64'(core_out_valid), 64'd0);
        chk("mid_rst_of", core_out_flit, 64'd0);
        chk("mid_rst_ovf", 64'(ej_overflow), 64'd0);
        chk("mid_rst_starve", 64'(inj_starve), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("mid_rel_cnt", 64'(inj_count), 64'd0);
        chk("mid_rel_rdy", 64'(core_in_ready), 64'd1);
        chk("mid_rel_ci", port4_ci, 64'd0);

        // Ejection full with a simultaneous pop: the arriving flit is kept.
        do_reset();
        port4_co = E1; tick();
        port4_co = E2; tick();
        port4_co = E3; tick();
        port4_co = E4; tick();
        port4_co = E5; core_out_ready = 1'b1; tick();
        chk("ejfp_ovf", 64'(ej_overflow), 64'd0);
        chk("ejfp_head", core_out_flit, E2);
        port4_co = '0;
        tick(); chk("ejfp_h3", core_out_flit, E3);
        tick(); chk("ejfp_h4", core_out_flit, E4);
        tick(); chk("ejfp_h5", core_out_flit, E5);
        tick(); chk("ejfp_empty", 64'(core_out_valid), 64'd0);
        chk("ejfp_ovf_end", 64'(ej_overflow), 64'd0);
        idle_inputs();

        // Starvation: threshold crossing, saturation without wrap, clear on ack.
        do_reset();
        core_in_valid = 1'b1; core_in_flit = A; tick();
        core_in_valid = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31) chk("starve_31", 64'(inj_starve), 64'd0);
            if (i == 32) chk("starve_32", 64'(inj_starve), 64'd1);
        end
        repeat (300) tick();
        chk("starve_sat", 64'(inj_starve), 64'd1);
        chk("starve_head", port4_ci, A);
        port4_ack = 1'b1; tick();
        port4_ack = 1'b0;
        chk("starve_clr", 64'(inj_starve), 64'd0);
        chk("starve_cnt0", 64'(inj_count), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            bit slow_ack;
            slow_ack = ((k / 400) % 2) == 1;
            core_in_valid  = ($urandom_range(0, 1) == 1);
            core_in_flit   = {$urandom, $urandom};
            port4_ack      = slow_ack ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) < 4);
            port4_co       = {$urandom, $urandom};
            port4_co[63]   = ($urandom_range(0, 9) < 4);
            core_out_ready = slow_ack ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            model_step();
            tick();
            model_compare(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
